// File: rtl/param_shift_register.sv
// param_shift_register
//   Parallel-load shift register with single-step left/right shifts and a
//   counted burst mode driven by a three-state controller.
//   Optional feature: define SHIFT_ROTATE_EN to add the 'rot' input, which
//   turns every shift into a rotate.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | accepts ld > start > single-step shift (sl xor sr)
//   RUN   | one shift per edge in the latched direction; busy high
//   DONE  | one-cycle completion pulse on done, then back to IDLE
module param_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ld,
  input  logic             sl,
  input  logic             sr,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic             arith,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             dir,
`ifdef SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fill_l, fill_r;
  logic [WIDTH-1:0]   shl, shr;

  // Shift candidates; fill bits are sampled live so they apply to burst shifts too.
  always_comb begin
    fill_l = sin_lsb;
    fill_r = arith ? out_q[WIDTH-1] : sin_msb;
`ifdef SHIFT_ROTATE_EN
    if (rot) begin
      fill_l = out_q[WIDTH-1];
      fill_r = out_q[0];
    end
`endif
    shl = {out_q[WIDTH-2:0], fill_l};
    shr = {fill_r, out_q[WIDTH-1:1]};
  end

  // Next-state logic; busy/done are computed here so they come straight from flops.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld) begin
          out_d = d_in;
        end else if (start) begin
          dir_d = dir;
          if (count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            rem_d   = count;
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end else if (sl && !sr) begin
          out_d = shl;
        end else if (sr && !sl) begin
          out_d = shr;
        end
      end
      RUN: begin
        out_d = dir_q ? shr : shl;
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; async reset also aborts any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out      = out_q;
  assign sout_msb = out_q[WIDTH-1];
  assign sout_lsb = out_q[0];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_param_shift_register.sv
// Directed bench for param_shift_register (WIDTH=8, CNT_W=4).
module tb_param_shift_register;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] d_in = '0;
  logic       ld = 0, sl = 0, sr = 0, sin_lsb = 0, sin_msb = 0, arith = 0;
  logic       start = 0, dir = 0;
  logic [3:0] count = '0;
`ifdef SHIFT_ROTATE_EN
  logic       rot = 0;
`endif
  logic [7:0] out;
  logic       sout_msb, sout_lsb, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  param_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .ld(ld), .sl(sl), .sr(sr),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .arith(arith), .start(start),
    .count(count), .dir(dir),
`ifdef SHIFT_ROTATE_EN
    .rot(rot),
`endif
    .out(out), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int  n;
  logic saw_done;

  initial begin
    // reset state
    #2;
    check("rst_out", 32'(out), 32'h00);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    step();
    reset = 1'b1;

    // load then shift left
    ld = 1; d_in = 8'hB5; step(); ld = 0;
    check("ld_b5", 32'(out), 32'hB5);
    sl = 1; sin_lsb = 1; step(); sl = 0; sin_lsb = 0;
    check("sl_6b", 32'(out), 32'h6B);
    check("sout_msb", 32'(sout_msb), 0);
    check("sout_lsb", 32'(sout_lsb), 1);

    // right shifts
    ld = 1; d_in = 8'hB5; step(); ld = 0;
    sr = 1; arith = 1; step(); sr = 0; arith = 0;
    check("sr_arith", 32'(out), 32'hDA);
    ld = 1; d_in = 8'hB5; step(); ld = 0;
    sr = 1; sin_msb = 0; step();
    check("sr_log0", 32'(out), 32'h5A);
    sin_msb = 1; step(); sr = 0; sin_msb = 0;
    check("sr_log1", 32'(out), 32'hAD);

    // left burst of 3, ld ignored while busy and in DONE
    ld = 1; d_in = 8'h81; step(); ld = 0;
    start = 1; count = 4'd3; dir = 0; step(); start = 0;
    check("b3_start_out", 32'(out), 32'h81);
    check("b3_start_busy", 32'(busy), 1);
    ld = 1; d_in = 8'hFF;
    step();
    check("b3_e1_out", 32'(out), 32'h02);
    check("b3_e1_busy", 32'(busy), 1);
    step();
    check("b3_e2_out", 32'(out), 32'h04);
    check("b3_e2_busy", 32'(busy), 1);
    step();
    check("b3_e3_out", 32'(out), 32'h08);
    check("b3_e3_busy", 32'(busy), 0);
    check("b3_e3_done", 32'(done), 1);
    step();
    check("b3_idle_out", 32'(out), 32'h08);
    check("b3_idle_done", 32'(done), 0);
    ld = 0;

    // long right burst (N > WIDTH) fills entirely with sin_msb
    ld = 1; d_in = 8'hA5; step(); ld = 0;
    start = 1; count = 4'd9; dir = 1; sin_msb = 1; step(); start = 0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      step();
    end
    check("b9_busy_cycles", 32'(n), 9);
    check("b9_done", 32'(done), 1);
    check("b9_out", 32'(out), 32'hFF);
    sin_msb = 0; step();

    // count = 0 burst
    ld = 1; d_in = 8'h3C; step(); ld = 0;
    start = 1; count = 4'd0; step(); start = 0;
    check("b0_busy", 32'(busy), 0);
    check("b0_done", 32'(done), 1);
    check("b0_out", 32'(out), 32'h3C);
    step();
    check("b0_done_clr", 32'(done), 0);

    // sl and sr together hold
    sl = 1; sr = 1; sin_lsb = 1; sin_msb = 1; step(); sl = 0; sr = 0; sin_lsb = 0; sin_msb = 0;
    check("slsr_hold", 32'(out), 32'h3C);

    // reset in 2nd RUN cycle of a 5-shift burst
    ld = 1; d_in = 8'h81; step(); ld = 0;
    start = 1; count = 4'd5; dir = 0; step(); start = 0;
    step();
    check("ab_e1_out", 32'(out), 32'h02);
    #2 reset = 1'b0;
    #1;
    check("ab_out", 32'(out), 32'h00);
    check("ab_busy", 32'(busy), 0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("ab_no_done", 32'(saw_done), 0);
    check("ab_idle_busy", 32'(busy), 0);
    ld = 1; d_in = 8'h5C; step(); ld = 0;
    check("ab_ld", 32'(out), 32'h5C);

`ifdef SHIFT_ROTATE_EN
    rot = 1;
    ld = 1; d_in = 8'h81; step(); ld = 0;
    sr = 1; step(); sr = 0;
    check("rot_r", 32'(out), 32'hC0);
    ld = 1; d_in = 8'h81; step(); ld = 0;
    sl = 1; step(); sl = 0;
    check("rot_l", 32'(out), 32'h03);
    rot = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_shift_register.md
PARAM_SHIFT_REGISTER -- requirements
Module: param_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (>= 2).
REQ-002 Parameter CNT_W, default 4, width of the burst shift-count input.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset  input  1  asynchronous active-low reset.
REQ-006 Port d_in  input  WIDTH  parallel load data.
REQ-007 Port ld  input  1  parallel load request.
REQ-008 Port sl  input  1  single-step shift-left request.
REQ-009 Port sr  input  1  single-step shift-right request.
REQ-010 Port sin_lsb  input  1  bit entering bit 0 on a left shift.
REQ-011 Port sin_msb  input  1  bit entering bit WIDTH-1 on a logical right shift.
REQ-012 Port arith  input  1  right shifts replicate out[WIDTH-1] instead of sin_msb.
REQ-013 Port start  input  1  burst start request.
REQ-014 Port count  input  CNT_W  burst shift count N.
REQ-015 Port dir  input  1  burst direction: 0 left, 1 right.
REQ-016 Port out  output  WIDTH  register contents.
REQ-017 Port sout_msb / sout_lsb  output  1 each  combinational out[WIDTH-1] / out[0].
REQ-018 Port busy  output  1  high while a burst is shifting.
REQ-019 Port done  output  1  one-cycle burst completion pulse.

Function
REQ-020 State machine SHALL have states IDLE, RUN, DONE; all register updates on clk rising edge.
REQ-021 In IDLE, priority SHALL be ld > start > (sl xor sr); ld loads d_in to out.
REQ-022 In IDLE, sl and sr both high without ld/start SHALL hold out unchanged.
REQ-023 Left shift: out <= {out[WIDTH-2:0], sin_lsb}; right shift: out <= {fill, out[WIDTH-1:1]}, fill = arith ? out[WIDTH-1] : sin_msb.
REQ-024 IDLE with start and count=N>0: load remaining counter with N, go to RUN; no shift on that edge.
REQ-025 IDLE with start and count=0: go directly to DONE; out unchanged.
REQ-026 RUN: one shift per edge in direction dir latched at start, remaining decremented; on the edge performing the Nth shift go to DONE.
REQ-027 busy SHALL be high exactly in RUN (N cycles); done high exactly in DONE (1 cycle); DONE always returns to IDLE.
REQ-028 In RUN and DONE, ld, sl, sr, start SHALL be ignored; sin_lsb, sin_msb, arith sampled live each shift.
REQ-029 Burst of N >= WIDTH SHALL shift N times (contents fully replaced by fill bits); no saturation.

Reset
REQ-030 reset low SHALL asynchronously force out=0, state IDLE, remaining=0, busy=0, done=0, including mid-burst (burst aborted, no done pulse).
REQ-031 After reset deasserts, first active edge SHALL behave as IDLE.

Configuration
REQ-032 Macro SHIFT_ROTATE_EN: when defined, input port rot (1 bit) SHALL exist; rot=1 makes every shift (single or burst) a rotate: left fill out[WIDTH-1], right fill out[0], overriding sin_lsb, sin_msb, arith.
REQ-033 Without SHIFT_ROTATE_EN, port rot SHALL be absent and no rotate path synthesised; behaviour per REQ-023.

Verification (WIDTH=8, CNT_W=4)
REQ-034 ld with d_in=8'hB5, then sl with sin_lsb=1 -> out 8'hB5 then 8'h6B; sout_msb=0.
REQ-035 out=8'hB5, sr with arith=1 -> 8'hDA; with arith=0, sin_msb=0 -> 8'h5A.
REQ-036 out=8'h81, start count=3 dir=0 sin_lsb=0 -> busy 3 cycles, out 8'h02, 8'h04, 8'h08, then done 1 cycle; ld during busy ignored.
REQ-037 start count=0 -> busy never high, done high 1 cycle, out unchanged; sl=sr=1 in IDLE -> out unchanged.
REQ-038 Reset low in 2nd RUN cycle of count=5 burst -> out 8'h00, busy 0, no done pulse; next ld works normally.
REQ-039 With SHIFT_ROTATE_EN, rot=1, out=8'h81, sr -> 8'hC0; sl from 8'h81 -> 8'h03.
